// File: rtl/sram_rd_streamer_if.sv
// Signal bundle for the SRAM read streamer: command/status, the SRAM read port, and the output stream.
// The slave modport is the streamer's view; master is the environment driving it.
interface sram_rd_streamer_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 14
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              sram_csbn;
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] sram_rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  start, base_addr, len, sram_rdata, m_ready,
        output busy, done, sram_csbn, sram_raddr, m_valid, m_data, m_last
    );

    modport master (
        output start, base_addr, len, sram_rdata, m_ready,
        input  busy, done, sram_csbn, sram_raddr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/sram_rd_streamer.sv
// Burst reader for a single-clock SRAM with 1-cycle registered read latency, feeding a
// valid/ready stream through a 2-entry skid FIFO so full throughput survives backpressure.
module sram_rd_streamer #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 14
) (
    input logic               clk,
    input logic               rst,
    sram_rd_streamer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  pop_cnt;
    logic              inflight;
    logic [DATA_W-1:0] fifo [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              done_q;

    logic              accept;
    logic              pop;
    logic              issue;
    logic              last_pop;
    logic              last_issue;
    logic [2:0]        occ;

    always_comb begin
        accept     = 1'b0;
        pop        = 1'b0;
        issue      = 1'b0;
        last_pop   = 1'b0;
        last_issue = 1'b0;
        occ        = '0;
        state_nx   = state;

        accept   = (state == IDLE) && bus.start;
        pop      = (count != 2'd0) && bus.m_ready;
        last_pop = pop && (pop_cnt == len_q - LEN_W'(1));
        // Credit: words buffered plus the read in flight, less the word leaving this cycle.
        occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue    = (state == READ) && (occ < 3'd2);
        last_issue = issue && (issue_cnt + LEN_W'(1) == len_q);

        case (state)
            IDLE:    if (bus.start && (bus.len != '0)) state_nx = READ;
            READ:    if (last_issue) state_nx = DRAIN;
            DRAIN:   if (last_pop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= (accept && (bus.len == '0)) || ((state == DRAIN) && last_pop);
            inflight <= issue;
            count    <= count + {1'b0, inflight} - {1'b0, pop};
            if (accept) begin
                base_q    <= bus.base_addr;
                len_q     <= bus.len;
                issue_cnt <= '0;
                pop_cnt   <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + LEN_W'(1);
                if (pop)   pop_cnt   <= pop_cnt + LEN_W'(1);
            end
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop)      rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && inflight) fifo[wr_ptr] <= bus.sram_rdata;
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.sram_csbn  = ~issue;
    assign bus.sram_raddr = issue ? (base_q + issue_cnt[ADDR_W-1:0]) : '0;
    assign bus.m_valid    = (count != 2'd0);
    assign bus.m_data     = (count != 2'd0) ? fifo[rd_ptr] : '0;
    assign bus.m_last     = (count != 2'd0) && (pop_cnt == len_q - LEN_W'(1));
endmodule
